// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/add ops, WIDTH-cycle shift-add multiply and
// restoring divide (divider only when ITER_ALU_DIV_EN is defined).
module iter_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       aluControl,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] ALUresult,
  output logic             Zero,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int SH_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
`ifdef ITER_ALU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // product accumulator / partial remainder
  logic [WIDTH-1:0] x_q, x_d;       // multiplicand / dividend shifting into quotient
  logic [WIDTH-1:0] y_q, y_d;       // multiplier / divisor
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] quick;
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH-1:0] step_res;

  assign in_ready  = (state_q == IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign ALUresult = res_q;
  assign Zero      = zero_q;

  function automatic logic is_iter(input logic [3:0] op);
`ifdef ITER_ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
`else
    return (op == OP_MUL);
`endif
  endfunction

  always_comb begin
    shamt = SrcB[SH_W-1:0];
    quick = '0;
    case (aluControl)
      OP_ADD: quick = SrcA + SrcB;
      OP_SUB: quick = SrcA - SrcB;
      OP_AND: quick = SrcA & SrcB;
      OP_OR:  quick = SrcA | SrcB;
      OP_XOR: quick = SrcA ^ SrcB;
      OP_SLT: quick = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLL: quick = SrcA << shamt;
      OP_SRL: quick = SrcA >> shamt;
      default: quick = '0;
    endcase
  end

  assign mul_sum = acc_q + (y_q[0] ? x_q : '0);

`ifdef ITER_ALU_DIV_EN
  // A zero divisor always passes the trial compare, which naturally yields
  // quotient = all ones and remainder = dividend.
  logic [WIDTH:0]   div_part;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem, div_quo;
  assign div_part = {acc_q, x_q[WIDTH-1]};
  assign div_ok   = (div_part >= {1'b0, y_q});
  assign div_rem  = div_ok ? WIDTH'(div_part - {1'b0, y_q}) : div_part[WIDTH-1:0];
  assign div_quo  = {x_q[WIDTH-2:0], div_ok};
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    x_d      = x_q;
    y_d      = y_q;
    res_d    = res_q;
    zero_d   = zero_q;
    step_res = mul_sum;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = aluControl;
          cnt_d = '0;
          if (is_iter(aluControl)) begin
            acc_d   = '0;
            x_d     = SrcA;
            y_d     = SrcB;
            state_d = BUSY;
          end else begin
            res_d   = quick;
            zero_d  = (quick == '0);
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
`ifdef ITER_ALU_DIV_EN
        if (op_q != OP_MUL) begin
          acc_d    = div_rem;
          x_d      = div_quo;
          step_res = (op_q == OP_REMU) ? div_rem : div_quo;
        end else begin
          acc_d = mul_sum;
          x_d   = x_q << 1;
          y_d   = y_q >> 1;
        end
`else
        acc_d = mul_sum;
        x_d   = x_q << 1;
        y_d   = y_q >> 1;
`endif
        // Final step lands directly in the result register.
        if (cnt_q == LAST) begin
          res_d   = step_res;
          zero_d  = (step_res == '0);
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Bench for iter_alu (WIDTH=32): vector table through a result scoreboard plus
// hand sequences for reset, DONE back-pressure and reset during a multiply.
module tb_iter_alu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] SrcA = '0, SrcB = '0;
  logic [3:0]  aluControl = '0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, Zero, out_valid;
  logic [31:0] ALUresult;

  iter_alu #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .SrcA(SrcA), .SrcB(SrcB), .aluControl(aluControl),
    .in_valid(in_valid), .in_ready(in_ready), .ALUresult(ALUresult), .Zero(Zero),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, exp;
    int          lat;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        zero;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int   lat;
    exp_t e;
    @(negedge clk);
    chk({v.name, " in_ready"}, {63'b0, in_ready}, 64'd1);
    in_valid = 1'b1; aluControl = v.op; SrcA = v.a; SrcB = v.b;
    sb_q.push_back('{res: v.exp, zero: (v.exp == 32'd0)});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; SrcA = $urandom; SrcB = $urandom; aluControl = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({v.name, " latency"}, 64'(lat), 64'(v.lat));
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({v.name, " result"}, {32'b0, ALUresult}, {32'b0, e.res});
      chk({v.name, " zero"}, {63'b0, Zero}, {63'b0, e.zero});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({v.name, " idle out_valid"}, {63'b0, out_valid}, 64'd0);
    chk({v.name, " held result"}, {32'b0, ALUresult}, {32'b0, v.exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs.push_back('{4'b0000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1,  "ADD ovf"});
    vecs.push_back('{4'b0001, 32'd5,        32'd5,        32'h0,        1,  "SUB zero"});
    vecs.push_back('{4'b0001, 32'd0,        32'd1,        32'hFFFFFFFF, 1,  "SUB wrap"});
    vecs.push_back('{4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1,  "AND"});
    vecs.push_back('{4'b0011, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1,  "OR"});
    vecs.push_back('{4'b0100, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1,  "XOR"});
    vecs.push_back('{4'b0101, 32'hFFFFFFFF, 32'h1,        32'h1,        1,  "SLT neg"});
    vecs.push_back('{4'b0101, 32'h1,        32'hFFFFFFFF, 32'h0,        1,  "SLT pos"});
    vecs.push_back('{4'b0110, 32'h1,        32'd31,       32'h80000000, 1,  "SLL 31"});
    vecs.push_back('{4'b0110, 32'h3,        32'h24,       32'h30,       1,  "SLL mask"});
    vecs.push_back('{4'b0111, 32'h80000000, 32'd31,       32'h1,        1,  "SRL 31"});
    vecs.push_back('{4'b1011, 32'h12345678, 32'h1,        32'h0,        1,  "op 1011"});
    vecs.push_back('{4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1,  "op 1111"});
    vecs.push_back('{4'b1000, 32'h10000,    32'h10000,    32'h0,        33, "MUL 2^32"});
    vecs.push_back('{4'b1000, 32'd7,        32'd6,        32'd42,       33, "MUL 7*6"});
    vecs.push_back('{4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        33, "MUL max"});
`ifdef ITER_ALU_DIV_EN
    vecs.push_back('{4'b1001, 32'd100,      32'd7,        32'd14,       33, "DIVU 100/7"});
    vecs.push_back('{4'b1010, 32'd100,      32'd7,        32'd2,        33, "REMU 100/7"});
    vecs.push_back('{4'b1001, 32'd9,        32'd0,        32'hFFFFFFFF, 33, "DIVU 9/0"});
    vecs.push_back('{4'b1010, 32'd9,        32'd0,        32'd9,        33, "REMU 9/0"});
    vecs.push_back('{4'b1001, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 33, "DIVU big"});
`else
    vecs.push_back('{4'b1001, 32'd100,      32'd7,        32'h0,        1,  "DIVU off"});
    vecs.push_back('{4'b1010, 32'd100,      32'd7,        32'h0,        1,  "REMU off"});
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst ALUresult", {32'b0, ALUresult}, 64'd0);
    chk("rst Zero", {63'b0, Zero}, 64'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready", {63'b0, in_ready}, 64'd1);

    foreach (vecs[i]) run_txn(vecs[i]);

    // DONE back-pressure: result held, requests ignored
    @(negedge clk);
    in_valid = 1'b1; aluControl = 4'b0000; SrcA = 32'd2; SrcB = 32'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1; aluControl = 4'b0001; SrcA = 32'd100; SrcB = 32'd1;
    for (int c = 0; c < 10; c++) begin
      chk("stall out_valid", {63'b0, out_valid}, 64'd1);
      chk("stall result", {32'b0, ALUresult}, 64'd5);
      chk("stall in_ready", {63'b0, in_ready}, 64'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall exit in_ready", {63'b0, in_ready}, 64'd1);
    chk("stall exit out_valid", {63'b0, out_valid}, 64'd0);
    chk("stall exit result", {32'b0, ALUresult}, 64'd5);
    repeat (3) @(negedge clk);
    chk("ignored req out_valid", {63'b0, out_valid}, 64'd0);

    // Reset during multiply, in the 10th busy cycle
    @(negedge clk);
    in_valid = 1'b1; aluControl = 4'b1000; SrcA = 32'd7; SrcB = 32'd6;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid-mul busy", {63'b0, in_ready}, 64'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort out_valid", {63'b0, out_valid}, 64'd0);
    chk("abort ALUresult", {32'b0, ALUresult}, 64'd0);
    chk("abort Zero", {63'b0, Zero}, 64'd1);
    chk("abort in_ready", {63'b0, in_ready}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort idle in_ready", {63'b0, in_ready}, 64'd1);
    repeat (30) begin
      @(negedge clk);
      if (out_valid) chk("aborted result shown", 64'd1, 64'd0);
    end
    run_txn('{4'b0000, 32'd2, 32'd3, 32'd5, 1, "ADD after abort"});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
